// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue
//  Purpose  : Instruction fetch unit with a DEPTH-entry instruction FIFO.
//             Keeps at most one icache request outstanding, takes the next
//             fetch PC from the branch predictor, redirects on ROB clear-up
//             and discards a stale in-flight response after a redirect.
//  Ports    : clk_in/rst_in/rdy_in        clock, async reset, global ready
//             rob_clear_up/rob_next_pc    flush request and redirect target
//             fetch_pc/start_fetch        icache request (held until accepted)
//             fetch_ready/inst/inst_addr  icache response (one-cycle pulse)
//             pred_next_pc                predictor's next PC for fetch_pc
//             start_decode/inst_out/
//             inst_addr_out/issue_signal  FIFO head toward decoder
//             count                       FIFO occupancy
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     rob_clear_up,
  input  logic [XLEN-1:0]          rob_next_pc,
  output logic [XLEN-1:0]          fetch_pc,
  output logic                     start_fetch,
  input  logic                     fetch_ready,
  input  logic [XLEN-1:0]          inst,
  input  logic [XLEN-1:0]          inst_addr,
  input  logic [XLEN-1:0]          pred_next_pc,
  output logic                     start_decode,
  output logic [XLEN-1:0]          inst_out,
  output logic [XLEN-1:0]          inst_addr_out,
  input  logic                     issue_signal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // no request outstanding
    S_WAIT = 2'd1,   // request outstanding, result wanted
    S_DROP = 2'd2    // request outstanding, result stale
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   redir_q, redir_d;
  logic              start_fetch_q, start_fetch_d;
  logic [CW-1:0]     count_q, count_d;
  logic [AW-1:0]     head_q, head_d;
  logic [AW-1:0]     tail_q, tail_d;
  logic [XLEN-1:0]   inst_mem_q [DEPTH];
  logic [XLEN-1:0]   addr_mem_q [DEPTH];

  logic              push_w;
  logic              pop_w;
  logic [CW-1:0]     next_count_w;
  logic              space_w;

  // A flush suppresses both FIFO operations; rdy_in low freezes everything.
  assign push_w = rdy_in && !rob_clear_up && (state_q == S_WAIT) && fetch_ready;
  assign pop_w  = rdy_in && !rob_clear_up && issue_signal && (count_q != '0);
  assign next_count_w = count_q + {{AW{1'b0}}, push_w} - {{AW{1'b0}}, pop_w};
  // A new request is only launched if a slot can be reserved for its result.
  assign space_w = (next_count_w < FULL_CNT);

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    redir_d       = redir_q;
    start_fetch_d = start_fetch_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    if (rdy_in) begin
      if (rob_clear_up) begin
        count_d = '0;
        head_d  = tail_q;
        unique case (state_q)
          S_IDLE: begin
            fetch_pc_d = rob_next_pc;
          end
          S_WAIT, S_DROP: begin
            if (fetch_ready) begin
              fetch_pc_d    = rob_next_pc;
              start_fetch_d = 1'b0;
              state_d       = S_IDLE;
            end else begin
              // fetch_pc must stay put for the request still in flight.
              redir_d = rob_next_pc;
              state_d = S_DROP;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end else begin
        count_d = next_count_w;
        if (pop_w)  head_d = head_q + AW'(1);
        if (push_w) tail_d = tail_q + AW'(1);
        unique case (state_q)
          S_IDLE: begin
            if (space_w) begin
              start_fetch_d = 1'b1;
              state_d       = S_WAIT;
            end
          end
          S_WAIT: begin
            if (fetch_ready) begin
              fetch_pc_d    = pred_next_pc;
              start_fetch_d = space_w;
              state_d       = space_w ? S_WAIT : S_IDLE;
            end
          end
          S_DROP: begin
            if (fetch_ready) begin
              fetch_pc_d    = redir_q;
              start_fetch_d = space_w;
              state_d       = space_w ? S_WAIT : S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= S_IDLE;
      fetch_pc_q    <= RESET_PC;
      redir_q       <= RESET_PC;
      start_fetch_q <= 1'b0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      redir_q       <= redir_d;
      start_fetch_q <= start_fetch_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // Storage is cleared on reset so the decoder-side outputs read zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        addr_mem_q[i] <= '0;
      end
    end else if (push_w) begin
      inst_mem_q[tail_q] <= inst;
      addr_mem_q[tail_q] <= inst_addr;
    end
  end

  assign fetch_pc      = fetch_pc_q;
  assign start_fetch   = start_fetch_q;
  assign count         = count_q;
  assign start_decode  = (count_q != '0);
  assign inst_out      = inst_mem_q[head_q];
  assign inst_addr_out = addr_mem_q[head_q];

  always @(posedge clk_in) begin
    if (!rst_in && rdy_in) begin
      assert (!(state_q == S_IDLE && fetch_ready))
        else $fatal(1, "inst_fetch_queue: fetch_ready with no request outstanding");
      assert (count_q <= FULL_CNT)
        else $fatal(1, "inst_fetch_queue: FIFO occupancy exceeds DEPTH");
    end
  end

endmodule
`default_nettype wire
